// File: rtl/gau_fil_stream_if.sv
// Stream bundle for gau_fil_stream: the pixel input side (src_*) and the
// filtered output side (dst_*). The filter connects through the slave modport;
// the pixel source and the downstream sink share the master modport.
interface gau_fil_stream_if #(
  parameter int DSIZE = 8
);
  logic             src_valid;
  logic             src_ready;
  logic             src_sof;
  logic [DSIZE-1:0] src_pixel;
  logic             dst_valid;
  logic             dst_ready;
  logic             dst_sof;
  logic             dst_eol;
  logic [DSIZE-1:0] dst_pixel;

  modport master (
    output src_valid, src_sof, src_pixel, dst_ready,
    input  src_ready, dst_valid, dst_sof, dst_eol, dst_pixel
  );

  modport slave (
    input  src_valid, src_sof, src_pixel, dst_ready,
    output src_ready, dst_valid, dst_sof, dst_eol, dst_pixel
  );
endinterface

// File: rtl/gau_fil_stream.sv
// Streaming 3x3 Gaussian smoothing filter, kernel [1 2 1; 2 4 2; 1 2 1]/16.
// Two line buffers hold the previous two input rows and two column registers
// hold the previous two window columns, so one result per accepted pixel
// once the window covers interior positions. Output is a one-deep register.
// Optional macro GAU_ROUND_EN selects round-half-up instead of truncation.
module gau_fil_stream #(
  parameter int DSIZE = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic            i_clk,
  input logic            i_rst,
  gau_fil_stream_if.slave s
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int SW = DSIZE + 4;

  logic [XW-1:0]    x, cx;
  logic [YW-1:0]    y, cy;
  logic             accept, emit;
  logic [DSIZE-1:0] lb0 [IMG_W];   // row y-1
  logic [DSIZE-1:0] lb1 [IMG_W];   // row y-2
  logic [DSIZE-1:0] col1 [3];      // column x-1: top, middle, bottom
  logic [DSIZE-1:0] col2 [3];      // column x-2: top, middle, bottom
  logic [DSIZE-1:0] top, mid;
  logic [SW-1:0]    sum;
  logic [DSIZE-1:0] result;

  function automatic logic [SW-1:0] ext(input logic [DSIZE-1:0] p);
    return SW'(p);
  endfunction

  assign s.src_ready = !s.dst_valid || s.dst_ready;
  assign accept      = s.src_valid && s.src_ready;

  // Effective position of the incoming pixel, window taps and kernel sum.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cx     = x;
    cy     = y;
    if (s.src_sof) begin
      cx = '0;
      cy = '0;
    end
    emit   = (cx >= XW'(2)) && (cy >= YW'(2));
    top    = lb1[cx];
    mid    = lb0[cx];
    sum    = ext(col2[0]) + (ext(col2[1]) << 1) + ext(col2[2])
           + (ext(col1[0]) << 1) + (ext(col1[1]) << 2) + (ext(col1[2]) << 1)
           + ext(top) + (ext(mid) << 1) + ext(s.src_pixel);
`ifdef GAU_ROUND_EN
    result = DSIZE'((sum + SW'(8)) >> 4);
`else
    result = DSIZE'(sum >> 4);
`endif
  end

  // Raster position counters; sof resynchronises to (0,0).
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_rst) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (s.src_sof) begin
        x <= XW'(1);
        y <= '0;
      end else if (x == XW'(IMG_W - 1)) begin
        x <= '0;
        y <= (y == YW'(IMG_H - 1)) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Line buffers and window columns advance on every accepted pixel.
  // NOTE: storage is deliberately not reset; stale contents are never emitted due to x/y gating.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[cx] <= mid;
      lb0[cx] <= s.src_pixel;
      col2    <= col1;
      col1    <= '{top, mid, s.src_pixel};
    end
  end

  // One-deep output register: load on an emitting accept, clear when drained.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s.dst_valid <= 1'b0;
      s.dst_pixel <= '0;
      s.dst_sof   <= 1'b0;
      s.dst_eol   <= 1'b0;
    end else if (accept && emit) begin
      s.dst_valid <= 1'b1;
      s.dst_pixel <= result;
      s.dst_sof   <= (cx == XW'(2)) && (cy == YW'(2));
      s.dst_eol   <= (cx == XW'(IMG_W - 1));
    end else if (s.dst_ready) begin
      s.dst_valid <= 1'b0;
    end
  end
endmodule

// File: doc/gau_fil_stream.md
Name: gau_fil_stream

Overview:
- Streaming 3x3 Gaussian smoothing filter, parametrised in pixel width and image geometry.
- Exact kernel [1 2 1; 2 4 2; 1 2 1]/16.
- Accepts a raster-order pixel stream with valid/ready flow control and builds the 3x3 window internally from two line buffers plus a window shift register.
- Emits filtered interior pixels with start-of-frame and end-of-line markers; sits between the pixel source and the edge/quantisation stages of the toonify pipeline.

Parameters:
- DSIZE, 8, pixel bit width.
- IMG_W, 640, pixels per input line; legal range is 3 or more.
- IMG_H, 480, lines per input frame; legal range is 3 or more.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_valid  input  1  input pixel valid
- o_ready  output  1  block can accept input this cycle
- i_sof  input  1  qualifies i_pixel as frame pixel (0,0); sampled only on accept
- i_pixel  input  DSIZE  input pixel, raster order
- o_valid  output  1  output pixel valid
- i_ready  input  1  downstream accepts output this cycle
- o_sof  output  1  o_pixel is output pixel (0,0)
- o_eol  output  1  o_pixel is the last pixel of an output line
- o_pixel  output  DSIZE  filtered pixel

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_valid=0, o_pixel=0, o_sof=0, o_eol=0, column counter x=0, row counter y=0.
- Line buffers and window registers are not reset. Their stale data is never emitted because of the y/x gating below.
- Accept: an input pixel is accepted on a rising edge with i_valid && o_ready.
- o_ready = !o_valid || i_ready. This is a one-deep output register with combinational pass-through of downstream ready.
- Position counters on accept:
  - If i_sof=1, the pixel is treated as (0,0): x<=1, y<=0. This applies mid-frame as well (resync) and discards the partial frame.
  - Otherwise x increments. At x==IMG_W-1, x wraps to 0 and y increments. At (IMG_W-1, IMG_H-1), y wraps to 0 (next frame implicit).
- Line buffers, per accept at column x: lb1[x]<=lb0[x], lb0[x]<=i_pixel. lb0 holds row y-1 and lb1 holds row y-2.
- Window: three 3-pixel columns shift left on accept. The newest column is {lb1[x], lb0[x], i_pixel}.
- Emission: the accepted pixel at (x,y) with x>=2 and y>=2 produces the filtered centre (x-1, y-1).
  - Output frame size is (IMG_W-2) x (IMG_H-2).
  - No output is produced for x<2 or y<2.
- Latency: o_valid rises on the same edge that accepts the triggering input pixel, i.e. 1 cycle.
- Output hold: o_valid, o_pixel, o_sof and o_eol hold stable while o_valid && !i_ready. o_valid clears on an i_ready edge unless a new emitting pixel is accepted on that same edge, in which case the new result is loaded.
- o_sof=1 for the result of input (2,2). o_eol=1 for the result of input x==IMG_W-1.
- Arithmetic:
  - Sum is DSIZE+4 bits: corners x1, edges x2, centre x4 (shifts only).
  - o_pixel = sum>>4.
  - Maximum sum is 16*(2^DSIZE-1), so no overflow and no saturation are needed.
- Simultaneous events: an i_sof accept that is also an emitting position cannot occur (sof forces x=0). A new accept concurrent with output drain is handled as above with no bubble.
- Reset mid-frame: outputs return to reset values immediately. The next frame must begin with i_sof or will be treated as starting at (0,0).

Optional Feature:
- Macro GAU_ROUND_EN.
- Defined: o_pixel = (sum+8)>>4, round-half-up. The result still fits DSIZE because (16M+8)>>4 = M.
- Undefined: o_pixel = sum>>4, truncation.

Test Plan:
- IMG_W=4, IMG_H=4, all pixels 100, i_ready=1 -> exactly 4 outputs, all 100. o_sof on the 1st output; o_eol on the 2nd and 4th.
- 5x5 frame, zero except (2,2)=160 -> 9 outputs in raster order 10,20,10,20,40,20,10,20,10.
- 3x3 frame, zero except centre=6 (sum 24) -> single output 1 without GAU_ROUND_EN, 2 with it. o_sof=o_eol=1.
- 4x4 ramp frame with i_ready toggling 1010... and random i_valid gaps -> outputs identical to the i_ready=1 run. o_pixel is stable while stalled. o_ready=0 whenever o_valid && !i_ready.
- i_sof asserted at input pixel 7 of a 4x4 frame of 50s, then a full 4x4 frame of 200s -> no outputs from the aborted prefix; 4 outputs of 200, the first with o_sof.
- Assert i_rst with o_valid=1 mid-frame, release, send a fresh 4x4 frame of 30s with i_sof -> outputs 0 during reset, then exactly 4 outputs of 30.
